// File: rtl/cfg_chain_loader.sv
// Byte-stream loader for the fabric configuration chain: serializes MSB-first
// onto ccff_head with one prog_en pulse per bit, holding fabric_reset until the
// whole chain is written. Optional CRC-8 trailer check when CFG_CRC_EN is defined.
module cfg_chain_loader #(
  parameter int CHAIN_LEN  = 512,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ccff_head,
  output logic       prog_en,
  output logic       fabric_reset,
  output logic       fabric_set,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);

  localparam int              CW        = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(CHAIN_LEN - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_SHIFT,
    S_CRC_LOAD,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [7:0]      hold_cnt;
  logic [7:0]      shreg;
  logic [2:0]      byte_bit;
  logic            session_start;

  // A new session may only begin from a resting state; start is ignored mid-session.
  assign session_start = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign fabric_set    = 1'b0;

`ifdef CFG_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`else
  assign crc_err = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      hold_cnt     <= 8'd0;
      shreg        <= 8'd0;
      byte_bit     <= 3'd0;
      in_ready     <= 1'b0;
      ccff_head    <= 1'b0;
      prog_en      <= 1'b0;
      fabric_reset <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CFG_CRC_EN
      crc          <= 8'd0;
      crc_err      <= 1'b0;
`endif
    end else begin
      prog_en <= 1'b0;
      if (session_start) begin
        state        <= S_HOLD;
        busy         <= 1'b1;
        done         <= 1'b0;
        fabric_reset <= 1'b1;
        hold_cnt     <= 8'd0;
        bit_cnt      <= '0;
`ifdef CFG_CRC_EN
        crc          <= 8'd0;
        crc_err      <= 1'b0;
`endif
      end else begin
        case (state)
          S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end

          S_LOAD: begin
            if (in_valid) begin
              shreg    <= in_data;
              byte_bit <= 3'd0;
              in_ready <= 1'b0;
              state    <= S_SHIFT;
            end
          end

          S_SHIFT: begin
            ccff_head <= shreg[7];
            prog_en   <= 1'b1;
            shreg     <= {shreg[6:0], 1'b0};
            bit_cnt   <= bit_cnt + CW'(1);
            byte_bit  <= byte_bit + 3'd1;
`ifdef CFG_CRC_EN
            crc       <= crc8_step(crc, shreg[7]);
`endif
            // Chain end wins over byte end: leftover low bits are dropped.
            if (bit_cnt == LAST_BIT) begin
`ifdef CFG_CRC_EN
              state    <= S_CRC_LOAD;
              in_ready <= 1'b1;
`else
              state    <= S_RELEASE;
              hold_cnt <= 8'd0;
`endif
            end else if (byte_bit == 3'd7) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end

`ifdef CFG_CRC_EN
          S_CRC_LOAD: begin
            if (in_valid) begin
              in_ready <= 1'b0;
              if (in_data == crc) begin
                state    <= S_RELEASE;
                hold_cnt <= 8'd0;
              end else begin
                state   <= S_ERROR;
                crc_err <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
`endif

          S_RELEASE: begin
            if (hold_cnt == HOLD_LAST) begin
              state        <= S_DONE;
              done         <= 1'b1;
              fabric_reset <= 1'b0;
              busy         <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Programs the fabric configuration chain (the chain of DFFSRQ cells inside each logical tile) from a byte-wide host stream.
- Serializes bytes MSB-first onto the chain head and issues one shift-enable pulse per bit.
- Holds the fabric's global set/reset during loading and releases it only after the full chain is written.
- Sits between the Tiny Tapeout IO wrapper and the fabric top.

Parameters:
CHAIN_LEN, 512, total configuration bits in the chain (1..65535).
RST_CYCLES, 4, cycles fabric_reset is held after start and before release (1..255).

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a programming session.
in_data  input  8  configuration byte; MSB is shifted first.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts in_data this cycle.
ccff_head  output  1  serial bit to the chain head; registered.
prog_en  output  1  chain shift enable, one cycle per bit; registered, aligned with ccff_head.
fabric_reset  output  1  drives the fabric global reset.
fabric_set  output  1  drives the fabric global set.
busy  output  1  session in progress.
done  output  1  chain fully loaded and fabric released (level).
crc_err  output  1  CRC mismatch; see Optional Feature.

Behaviour:
- Reset values:
  - fabric_reset=1.
  - fabric_set, in_ready, ccff_head, prog_en, busy, done, crc_err all 0.
  - bit counter = 0, hold counter = 0, state = IDLE.
- Reset asserted mid-session aborts immediately: all outputs return to reset values and the chain contents are undefined.
- fabric_set is held 0 in every state.
- States:
  - IDLE:
    - fabric_reset=1.
    - start -> HOLD; busy=1 from the next cycle.
  - HOLD:
    - fabric_reset=1; counts RST_CYCLES cycles, then -> LOAD.
  - LOAD:
    - in_ready=1.
    - On in_valid & in_ready: capture byte into the shift register; -> SHIFT.
  - SHIFT:
    - Each cycle: ccff_head = shreg[7], prog_en=1, shift left, bit_cnt++.
    - After 8 bits -> LOAD.
    - When bit_cnt reaches CHAIN_LEN, go to RELEASE immediately, even mid-byte; remaining low bits of that byte are discarded.
  - RELEASE:
    - fabric_reset=1 for RST_CYCLES more cycles, then -> DONE.
  - DONE:
    - fabric_reset=0, done=1, busy=0.
    - start -> HOLD: new session; done clears and bit_cnt clears.
- start is ignored in HOLD, LOAD, SHIFT and RELEASE.
- in_valid is ignored outside LOAD; it is never consumed while in_ready=0.
- prog_en is 0 outside SHIFT. Exactly CHAIN_LEN prog_en pulses occur per session.
- Throughput: 9 cycles per full byte (1 LOAD handshake + 8 SHIFT), with no bubbles when in_valid is held high.
- Latency: start at cycle T gives first in_ready at T+1+RST_CYCLES.
- bit_cnt width is $clog2(CHAIN_LEN+1). No wrap: the counter stops at CHAIN_LEN.

Optional Feature:
Macro CFG_CRC_EN.
- Defined:
  - CRC-8 (poly 0x07, init 0x00, MSB-first) is computed over every bit driven with prog_en=1.
  - After CHAIN_LEN bits, the FSM enters CRC_LOAD (in_ready=1) and accepts one more byte, which is compared with the CRC.
  - Match -> RELEASE.
  - Mismatch -> crc_err=1 and enter FAIL: fabric_reset stays 1, done stays 0, busy=0.
  - start from FAIL begins a new session and clears crc_err.
- Undefined: no CRC byte is expected, and crc_err is tied to 0.

Test Plan:
1. Reset, then start with CHAIN_LEN=16, RST_CYCLES=4, bytes 0xA5, 0x3C streamed with in_valid=1 -> first in_ready 5 cycles after start; ccff_head sequence 1010010100111100 on 16 prog_en pulses; done=1 and fabric_reset=0 exactly 4 cycles after the last pulse.
2. CHAIN_LEN=12, bytes 0xFF, 0x0F -> exactly 12 pulses: eight 1s, then 0000; low nibble discarded; no third in_ready.
3. in_valid gaps (byte 2 presented 10 cycles late) -> in_ready stays high; no prog_en pulses during the gap; output sequence unchanged.
4. Reset asserted after 5 pulses -> all outputs at reset values next edge; fabric_reset=1; a new start programs all 16 bits correctly.
5. start pulsed during SHIFT and RELEASE -> ignored. start in DONE -> done=0, fabric_reset=1, new session runs normally.
6. CFG_CRC_EN, CHAIN_LEN=8, data 0x01:
   - CRC byte 0x07 -> done=1, crc_err=0.
   - CRC byte 0x00 -> crc_err=1, fabric_reset remains 1.
